exec_unit: RTL and testbench

//  Execute stage downstream of the windowed register file. Consumes operands r1/r2,

---
 rtl/exec_pkg.sv | 36 +++
 rtl/exec_alu.sv | 60 ++++++
 rtl/exec_unit.sv | 139 +++++++++++++
 tb/tb_exec_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// exec_pkg: shared opcodes, FSM encoding and datapath defaults for the execute stage.
// rev 1.0
`default_nettype none

package exec_pkg;

  localparam int WIDTH_DEF      = 16;
  localparam int RA_W_DEF       = 2;
  localparam int MUL_CYCLES_DEF = 16;

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_SHL  = 4'd7;
  localparam logic [3:0] OP_SHR  = 4'd8;
  localparam logic [3:0] OP_MOV  = 4'd9;
  localparam logic [3:0] OP_MUL  = 4'd10;
  localparam logic [3:0] OP_WINP = 4'd11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_WB   = 2'd2
  } state_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_MOV);
  endfunction

endpackage

`default_nettype wire

// File: rtl/exec_alu.sv
// exec_alu: combinational single-cycle ALU, opcodes ADD..MOV -> {result, carry}.
// rev 1.0
`default_nettype none

module exec_alu
  import exec_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [3:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o
);

  logic [WIDTH:0] wide;
  logic [3:0]     sh;

  assign sh = b_i[3:0];

  always_comb begin
    wide     = '0;
    result_o = '0;
    carry_o  = 1'b0;
    case (op_i)
      OP_ADD: begin
        wide     = {1'b0, a_i} + {1'b0, b_i};
        result_o = wide[WIDTH-1:0];
        carry_o  = wide[WIDTH];
      end
      OP_SUB: begin
        // Top bit of the widened difference is the borrow (a < b).
        wide     = {1'b0, a_i} - {1'b0, b_i};
        result_o = wide[WIDTH-1:0];
        carry_o  = wide[WIDTH];
      end
      OP_AND: result_o = a_i & b_i;
      OP_OR:  result_o = a_i | b_i;
      OP_XOR: result_o = a_i ^ b_i;
      OP_NOT: result_o = ~a_i;
      OP_SHL: begin
        wide     = {1'b0, a_i} << sh;
        result_o = wide[WIDTH-1:0];
        carry_o  = wide[WIDTH];
      end
      OP_SHR: begin
        // Guard bit below bit 0 catches the last bit shifted out; zero for sh==0.
        wide     = {a_i, 1'b0} >> sh;
        result_o = wide[WIDTH:1];
        carry_o  = wide[0];
      end
      OP_MOV: result_o = a_i;
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/exec_unit.sv
// exec_unit: execute stage with ALU, 16-step shift-add MUL and register-window pointer.
// rev 1.0
`default_nettype none

module exec_unit
  import exec_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int MUL_CYCLES = MUL_CYCLES_DEF,
  parameter int RA_W       = RA_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  output logic             issue_ready,
  input  logic [3:0]       opcode,
  input  logic [RA_W-1:0]  dst,
  input  logic [RA_W-1:0]  imm,
  input  logic [WIDTH-1:0] r1,
  input  logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] data_in,
  output logic [RA_W-1:0]  wr,
  output logic             _regfile_write,
  output logic [RA_W-1:0]  wind,
  output logic [2:0]       flags
);

  localparam int                CNT_W    = $clog2(MUL_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_CYCLES - 1);

  state_t           state_q, state_d;
  logic             up_q;
  logic [WIDTH-1:0] data_in_q, data_in_d;
  logic [RA_W-1:0]  wr_q, wr_d, wind_q, wind_d;
  logic [2:0]       flags_q, flags_d;
  logic             wbw_q, wbw_d;
  logic [WIDTH-1:0] mcand_q, mcand_d, mplier_q, mplier_d, acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_step, alu_res;
  logic             alu_c, accept;

  exec_alu #(.WIDTH(WIDTH)) u_alu (
    .op_i    (opcode),
    .a_i     (r1),
    .b_i     (r2),
    .result_o(alu_res),
    .carry_o (alu_c)
  );

  // up_q keeps ready low during reset and until the first edge after release.
  assign issue_ready    = up_q && (state_q == ST_IDLE);
  assign accept         = issue_valid && issue_ready;
  assign acc_step       = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign data_in        = data_in_q;
  assign wr             = wr_q;
  assign wind           = wind_q;
  assign flags          = flags_q;
  assign _regfile_write = (state_q == ST_WB) && wbw_q;

  always_comb begin
    state_d   = state_q;
    data_in_d = data_in_q;
    wr_d      = wr_q;
    wind_d    = wind_q;
    flags_d   = flags_q;
    wbw_d     = wbw_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          wr_d    = dst;
          wbw_d   = 1'b0;
          state_d = ST_WB;
          if (is_alu_op(opcode)) begin
            data_in_d = alu_res;
            flags_d   = {alu_res == '0, alu_res[WIDTH-1], alu_c};
            wbw_d     = 1'b1;
          end else if (opcode == OP_MUL) begin
            mcand_d  = r1;
            mplier_d = r2;
            acc_d    = '0;
            cnt_d    = '0;
            wbw_d    = 1'b1;
            state_d  = ST_MUL;
          end else if (opcode == OP_WINP) begin
            wind_d = wind_q + imm;
          end
        end
      end
      ST_MUL: begin
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          data_in_d = acc_step;
          flags_d   = {acc_step == '0, acc_step[WIDTH-1], 1'b0};
          state_d   = ST_WB;
        end
      end
      ST_WB:   state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      up_q      <= 1'b0;
      data_in_q <= '0;
      wr_q      <= '0;
      wind_q    <= '0;
      flags_q   <= '0;
      wbw_q     <= 1'b0;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      up_q      <= 1'b1;
      data_in_q <= data_in_d;
      wr_q      <= wr_d;
      wind_q    <= wind_d;
      flags_q   <= flags_d;
      wbw_q     <= wbw_d;
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_exec_unit.sv
// tb_exec_unit: directed vectors with a scoreboard queue checked by a writeback monitor.
// rev 1.0
`default_nettype none

module tb_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [3:0]  opcode;
  logic [1:0]  dst, imm, wr, wind;
  logic [15:0] r1, r2, data_in;
  logic        _regfile_write;
  logic [2:0]  flags;

  exec_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .opcode        (opcode),
    .dst           (dst),
    .imm           (imm),
    .r1            (r1),
    .r2            (r2),
    .data_in       (data_in),
    .wr            (wr),
    ._regfile_write(_regfile_write),
    .wind          (wind),
    .flags         (flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] d;
    logic [1:0]  w;
    logic [2:0]  f;
    int          due;
  } exp_t;

  typedef struct {
    logic [3:0]  op;
    logic [1:0]  d;
    logic [15:0] a;
    logic [15:0] b;
    bit          wr_exp;
    logic [15:0] ed;
    logic [2:0]  ef;
    int          lat;
  } vec_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   wcount = 0;
  logic [2:0] last_flags = 3'b000;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Writeback monitor: every write pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && _regfile_write === 1'b1) begin
      exp_t e;
      wcount++;
      if (sb.size() == 0) begin
        chk("unexpected_write", 32'(data_in), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        chk("wb_data", 32'(data_in), 32'(e.d));
        chk("wb_reg", 32'(wr), 32'(e.w));
        chk("wb_flags", 32'(flags), 32'(e.f));
        chk("wb_cycle", 32'(cyc), 32'(e.due));
        chk("wb_ready_low", 32'(issue_ready), 32'd0);
      end
    end
  end

  task automatic issue(input vec_t v, input logic [1:0] im);
    int n = 0;
    @(negedge clk);
    opcode = v.op; dst = v.d; imm = im; r1 = v.a; r2 = v.b; issue_valid = 1'b1;
    while (!issue_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!issue_ready) begin
      chk("issue_timeout", 32'd0, 32'd1);
      issue_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    issue_valid = 1'b0;
    r1 = 16'hDEAD;
    r2 = 16'hBEEF;
    if (v.wr_exp) begin
      sb.push_back('{v.ed, v.d, v.ef, cyc + v.lat - 1});
      last_flags = v.ef;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(sb.size()), 32'd0);
  endtask

  vec_t vecs[] = '{
    '{4'd1,  2'd2, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 3'b101, 1},
    '{4'd2,  2'd1, 16'h0001, 16'h0002, 1'b1, 16'hFFFF, 3'b011, 1},
    '{4'd3,  2'd3, 16'hF0F0, 16'hFF00, 1'b1, 16'hF000, 3'b010, 1},
    '{4'd4,  2'd0, 16'h00F0, 16'h0F00, 1'b1, 16'h0FF0, 3'b000, 1},
    '{4'd5,  2'd1, 16'hA5A5, 16'hFFFF, 1'b1, 16'h5A5A, 3'b000, 1},
    '{4'd6,  2'd2, 16'h0000, 16'h1234, 1'b1, 16'hFFFF, 3'b010, 1},
    '{4'd9,  2'd3, 16'h1234, 16'h0000, 1'b1, 16'h1234, 3'b000, 1},
    '{4'd8,  2'd0, 16'h0003, 16'h0001, 1'b1, 16'h0001, 3'b001, 1},
    '{4'd7,  2'd1, 16'h8000, 16'h0000, 1'b1, 16'h8000, 3'b010, 1},
    '{4'd7,  2'd2, 16'h8001, 16'h0001, 1'b1, 16'h0002, 3'b001, 1},
    '{4'd8,  2'd3, 16'h8000, 16'h0011, 1'b1, 16'h4000, 3'b000, 1},
    '{4'd10, 2'd1, 16'd300,  16'd250,  1'b1, 16'h24F8, 3'b000, 17},
    '{4'd10, 2'd2, 16'h0100, 16'h0100, 1'b1, 16'h0000, 3'b100, 17},
    '{4'd10, 2'd3, 16'd100,  16'd100,  1'b1, 16'h2710, 3'b000, 17},
    '{4'd10, 2'd0, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0001, 3'b000, 17},
    '{4'd0,  2'd1, 16'h1111, 16'h2222, 1'b0, 16'h0000, 3'b000, 1},
    '{4'd14, 2'd2, 16'h1111, 16'h2222, 1'b0, 16'h0000, 3'b000, 1}
  };

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc0;
    int acc_c[3];
    int n;
    rst_n = 1'b0; issue_valid = 1'b0; opcode = 4'd0; dst = 2'd0; imm = 2'd0;
    r1 = 16'h0; r2 = 16'h0;
    #12;
    chk("rst_ready", 32'(issue_ready), 32'd0);
    chk("rst_data", 32'(data_in), 32'd0);
    chk("rst_write", 32'(_regfile_write), 32'd0);
    chk("rst_wind", 32'(wind), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_release", 32'(issue_ready), 32'd1);

    foreach (vecs[i]) begin
      issue(vecs[i], 2'd0);
      if (!vecs[i].wr_exp) chk("flags_hold_nop", 32'(flags), 32'(last_flags));
    end
    drain();

    // Window pointer: 0 -> 2 -> (2+3) mod 4 = 1, no writes, flags untouched.
    issue('{4'd11, 2'd0, 16'h0, 16'h0, 1'b0, 16'h0, 3'b000, 1}, 2'd2);
    chk("winp_wind_a", 32'(wind), 32'd2);
    issue('{4'd11, 2'd3, 16'h0, 16'h0, 1'b0, 16'h0, 3'b000, 1}, 2'd3);
    chk("winp_wind_b", 32'(wind), 32'd1);
    chk("winp_ready_wb", 32'(issue_ready), 32'd0);
    @(posedge clk); #1;
    chk("winp_ready_back", 32'(issue_ready), 32'd1);
    chk("flags_hold_winp", 32'(flags), 32'(last_flags));
    issue('{4'd11, 2'd0, 16'h0, 16'h0, 1'b0, 16'h0, 3'b000, 1}, 2'd3);
    chk("winp_wrap", 32'(wind), 32'd0);

    // Valid held high across three ADDs: one accept every other cycle.
    wc0 = wcount;
    @(negedge clk);
    opcode = 4'd1; dst = 2'd1; r1 = 16'd1; r2 = 16'd2; issue_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = 0;
      while (!issue_ready && n < 10) begin
        @(negedge clk);
        n++;
      end
      @(posedge clk); #1;
      acc_c[k] = cyc;
      sb.push_back('{16'd3, 2'd1, 3'b000, cyc});
    end
    issue_valid = 1'b0;
    drain();
    repeat (3) @(posedge clk);
    chk("b2b_spacing", 32'(acc_c[2] - acc_c[0]), 32'd4);
    chk("b2b_writes", 32'(wcount - wc0), 32'd3);

    // Reset in the middle of a MUL aborts it without a write.
    issue('{4'd1, 2'd2, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 3'b101, 1}, 2'd0);
    issue('{4'd11, 2'd0, 16'h0, 16'h0, 1'b0, 16'h0, 3'b000, 1}, 2'd2);
    issue('{4'd10, 2'd3, 16'd7, 16'd9, 1'b1, 16'd63, 3'b000, 17}, 2'd0);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    sb.delete();
    chk("midmul_data", 32'(data_in), 32'd0);
    chk("midmul_wr", 32'(wr), 32'd0);
    chk("midmul_write", 32'(_regfile_write), 32'd0);
    chk("midmul_wind", 32'(wind), 32'd0);
    chk("midmul_flags", 32'(flags), 32'd0);
    chk("midmul_ready", 32'(issue_ready), 32'd0);
    wc0 = wcount;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    #1;
    chk("release_ready_low", 32'(issue_ready), 32'd0);
    @(posedge clk); #1;
    chk("release_ready_high", 32'(issue_ready), 32'd1);
    repeat (20) @(posedge clk);
    chk("aborted_no_write", 32'(wcount - wc0), 32'd0);

    // Unit still usable after the abort.
    issue('{4'd10, 2'd3, 16'd7, 16'd9, 1'b1, 16'd63, 3'b000, 17}, 2'd0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
